// File: rtl/glb_sram_cfg_initiator_pkg.sv
// glb_sram_cfg_initiator_pkg: GLB cfg-chain widths and initiator FSM encoding
package glb_sram_cfg_initiator_pkg;
    localparam int CGRA_CFG_ADDR_WIDTH = 32;
    localparam int CGRA_CFG_DATA_WIDTH = 32;
    localparam int NUM_GLB_TILES       = 16;
    typedef enum logic [2:0] {IDLE, WR, RD, WAIT, RSP, FLUSH} sram_cfg_init_state_e;
endpackage

// File: rtl/glb_sram_cfg_initiator.sv
// glb_sram_cfg_initiator: head-of-chain master issuing one GLB SRAM cfg read/write at a time
module glb_sram_cfg_initiator
    import glb_sram_cfg_initiator_pkg::*;
#(
    parameter int ADDR_WIDTH     = CGRA_CFG_ADDR_WIDTH,
    parameter int DATA_WIDTH     = CGRA_CFG_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_WIDTH      = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  cfg_wr_en,
    output logic                  cfg_wr_clk_en,
    output logic [ADDR_WIDTH-1:0] cfg_wr_addr,
    output logic [DATA_WIDTH-1:0] cfg_wr_data,
    output logic                  cfg_rd_en,
    output logic                  cfg_rd_clk_en,
    output logic [ADDR_WIDTH-1:0] cfg_rd_addr,
    input  logic [DATA_WIDTH-1:0] cfg_rd_data,
    input  logic                  cfg_rd_data_valid
);
    localparam logic [CNT_WIDTH-1:0] CNT_TIMEOUT    = CNT_WIDTH'(TIMEOUT_CYCLES);
    localparam logic [CNT_WIDTH-1:0] CNT_FLUSH_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    sram_cfg_init_state_e  state, state_d;
    logic [CNT_WIDTH-1:0]  cnt, cnt_d;
    logic                  wr_en_d, rd_en_d, rsp_valid_d, rsp_err_d;
    logic [ADDR_WIDTH-1:0] wr_addr_d, rd_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_d, rsp_rdata_d;

    assign req_ready     = state == IDLE;
    assign cfg_wr_clk_en = 1'b1;
    assign cfg_rd_clk_en = 1'b1;

    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        wr_en_d     = 1'b0;
        rd_en_d     = 1'b0;
        wr_addr_d   = cfg_wr_addr;
        wr_data_d   = cfg_wr_data;
        rd_addr_d   = cfg_rd_addr;
        rsp_valid_d = rsp_valid;
        rsp_rdata_d = rsp_rdata;
        rsp_err_d   = rsp_err;
        case (state)
            IDLE: if (req_valid) begin
                cnt_d = '0;
                if (req_write) begin
                    state_d   = WR;
                    wr_en_d   = 1'b1;
                    wr_addr_d = req_addr;
                    wr_data_d = req_wdata;
                end else begin
                    state_d   = RD;
                    rd_en_d   = 1'b1;
                    rd_addr_d = req_addr;
                end
            end
            WR: begin
                state_d     = RSP;
                rsp_valid_d = 1'b1;
                rsp_rdata_d = '0;
                rsp_err_d   = 1'b0;
            end
            // cnt tracks cycles since the rd_en pulse, so it reads 1 on the first WAIT cycle
            RD: begin
                state_d = WAIT;
                cnt_d   = cnt + 1'b1;
            end
            WAIT: begin
                cnt_d = cnt + 1'b1;
                if (cfg_rd_data_valid) begin
                    state_d     = RSP;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = cfg_rd_data;
                    rsp_err_d   = 1'b0;
                end else if (cnt == CNT_TIMEOUT) begin
                    state_d     = RSP;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                end
            end
            RSP: if (rsp_ready) begin
                rsp_valid_d = 1'b0;
                cnt_d       = '0;
                state_d     = rsp_err ? FLUSH : IDLE;
            end
            // a timed-out read may still return; swallow it before the next op
            FLUSH: begin
                cnt_d   = cnt + 1'b1;
                state_d = cnt == CNT_FLUSH_LAST ? IDLE : FLUSH;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            cfg_wr_en   <= 1'b0;
            cfg_rd_en   <= 1'b0;
            cfg_wr_addr <= '0;
            cfg_wr_data <= '0;
            cfg_rd_addr <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            cfg_wr_en   <= wr_en_d;
            cfg_rd_en   <= rd_en_d;
            cfg_wr_addr <= wr_addr_d;
            cfg_wr_data <= wr_data_d;
            cfg_rd_addr <= rd_addr_d;
            rsp_valid   <= rsp_valid_d;
            rsp_rdata   <= rsp_rdata_d;
            rsp_err     <= rsp_err_d;
        end
    end
endmodule

// File: tb/tb_glb_sram_cfg_initiator.sv
// tb_glb_sram_cfg_initiator: transaction-timeline model of the cfg initiator with directed and random traffic
module tb_glb_sram_cfg_initiator;
    localparam int TO = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic        cfg_wr_en, cfg_wr_clk_en, cfg_rd_en, cfg_rd_clk_en;
    logic [31:0] cfg_wr_addr, cfg_wr_data, cfg_rd_addr;
    logic [31:0] cfg_rd_data = '0;
    logic        cfg_rd_data_valid = 1'b0;

    glb_sram_cfg_initiator #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .cfg_wr_en(cfg_wr_en), .cfg_wr_clk_en(cfg_wr_clk_en), .cfg_wr_addr(cfg_wr_addr),
        .cfg_wr_data(cfg_wr_data), .cfg_rd_en(cfg_rd_en), .cfg_rd_clk_en(cfg_rd_clk_en),
        .cfg_rd_addr(cfg_rd_addr), .cfg_rd_data(cfg_rd_data), .cfg_rd_data_valid(cfg_rd_data_valid)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Chain responder: returns cur_data cur_lat cycles after each rd_en pulse (cur_lat 0 = silent)
    int          cur_lat = 0;
    logic [31:0] cur_data = '0;
    bit          stray = 1'b0;
    int          pend = 0;
    logic [31:0] pend_data = '0;

    always @(posedge clk) begin
        #2;
        cfg_rd_data_valid = 1'b0;
        cfg_rd_data = $urandom;
        if (reset) pend = 0;
        else begin
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    cfg_rd_data_valid = 1'b1;
                    cfg_rd_data = pend_data;
                end
            end else if (stray) cfg_rd_data_valid = 1'b1;
            if (cfg_rd_en && cur_lat > 0) begin
                pend = cur_lat;
                pend_data = cur_data;
            end
        end
    end

    // Timeline model: each op is described by the cycle numbers of its strobe, response and next free slot
    bit          outstanding = 0, waiting = 0, m_rsp_e = 0, m_wr_en = 0, m_rd_en = 0;
    int          ready_at = 0, rsp_at = 0, rd_cycle = 0;
    logic [31:0] m_rsp_d = '0, m_wr_addr = '0, m_wr_data = '0, m_rd_addr = '0;

    always @(posedge clk) begin : model
        int c;
        c = cyc;
        cyc++;
        m_wr_en = 0;
        m_rd_en = 0;
        if (reset) begin
            outstanding = 0; waiting = 0; ready_at = 0; m_rsp_d = '0; m_rsp_e = 0;
            m_wr_addr = '0; m_wr_data = '0; m_rd_addr = '0;
        end else if (!outstanding && c >= ready_at && req_valid) begin
            outstanding = 1;
            if (req_write) begin
                m_wr_en = 1; m_wr_addr = req_addr; m_wr_data = req_wdata;
                waiting = 0; rsp_at = cyc + 1; m_rsp_d = '0; m_rsp_e = 0;
            end else begin
                m_rd_en = 1; m_rd_addr = req_addr; rd_cycle = cyc; waiting = 1;
            end
        end else if (waiting && c > rd_cycle) begin
            if (cfg_rd_data_valid) begin
                waiting = 0; rsp_at = cyc; m_rsp_d = cfg_rd_data; m_rsp_e = 0;
            end else if (c - rd_cycle == TO) begin
                waiting = 0; rsp_at = cyc; m_rsp_d = '0; m_rsp_e = 1;
            end
        end else if (outstanding && !waiting && c >= rsp_at && rsp_ready) begin
            outstanding = 0;
            ready_at = m_rsp_e ? cyc + TO : cyc;
        end
    end

    always @(negedge clk) begin
        chk("wr_clk_en", cfg_wr_clk_en, 1);
        chk("rd_clk_en", cfg_rd_clk_en, 1);
        if (reset) begin
            chk("rst_req_ready", req_ready, 1);
            chk("rst_outputs", {rsp_valid, rsp_err, cfg_wr_en, cfg_rd_en}, 0);
            chk("rst_vectors", {rsp_rdata, cfg_wr_addr} | {cfg_wr_data, cfg_rd_addr}, 0);
        end else begin : cmp
            bit ev;
            ev = outstanding && !waiting && cyc >= rsp_at;
            chk("req_ready", req_ready, !outstanding && cyc >= ready_at);
            chk("cfg_wr_en", cfg_wr_en, m_wr_en);
            chk("cfg_rd_en", cfg_rd_en, m_rd_en);
            chk("cfg_wr_addr", cfg_wr_addr, m_wr_addr);
            chk("cfg_wr_data", cfg_wr_data, m_wr_data);
            chk("cfg_rd_addr", cfg_rd_addr, m_rd_addr);
            chk("rsp_valid", rsp_valid, ev);
            if (ev) begin
                chk("rsp_rdata", rsp_rdata, m_rsp_d);
                chk("rsp_err", rsp_err, m_rsp_e);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request and return in the strobe cycle that follows acceptance
    task automatic send(input bit wr, input logic [31:0] a, input logic [31:0] d, input int lat, input logic [31:0] rd);
        int n;
        n = 0;
        cur_lat = lat;
        cur_data = rd;
        req_valid = 1; req_write = wr; req_addr = a; req_wdata = d;
        while (!req_ready && n < 400) begin step(); n++; end
        chk("accept_within_bound", n < 400, 1);
        step();
        req_valid = 0; req_write = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        while (!rsp_valid && n < 400) begin step(); n++; end
        chk("rsp_within_bound", n < 400, 1);
    endtask

    task automatic finish_rsp(input int hold);
        repeat (hold) step();
        rsp_ready = 1;
        step();
        rsp_ready = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish within bound");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1);
    end

    initial begin
        int n, lat, sel;
        logic [31:0] a;
        req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0; rsp_ready = 0;
        repeat (3) @(posedge clk);
        #1 reset = 0;
        chk("lit_reset_ready", req_ready, 1);
        chk("lit_reset_rsp_valid", rsp_valid, 0);
        step();
        send(1, 32'h0004_0010, 32'hDEADBEEF, 0, '0);
        chk("lit_wr_pulse", cfg_wr_en, 1);
        chk("lit_wr_addr", cfg_wr_addr, 32'h0004_0010);
        chk("lit_wr_data", cfg_wr_data, 32'hDEADBEEF);
        chk("lit_wr_no_rd", cfg_rd_en, 0);
        step();
        chk("lit_wr_pulse_end", cfg_wr_en, 0);
        chk("lit_wr_rsp", {rsp_valid, rsp_err}, 2'b10);
        chk("lit_wr_rdata", rsp_rdata, 0);
        finish_rsp(0);
        send(0, 32'h0001_0200, '0, 7, 32'h12345678);
        chk("lit_rd_pulse", cfg_rd_en, 1);
        wait_rsp(n);
        chk("lit_rd_latency", n, 8);
        chk("lit_rd_rdata", rsp_rdata, 32'h12345678);
        chk("lit_rd_err", rsp_err, 0);
        finish_rsp(0);
        send(0, 32'h0002_0000, '0, 70, 32'hBADBAD00);
        wait_rsp(n);
        chk("lit_to_latency", n, TO + 1);
        chk("lit_to_err", rsp_err, 1);
        chk("lit_to_rdata", rsp_rdata, 0);
        finish_rsp(0);
        send(0, 32'h0002_0004, '0, 5, 32'hCAFEF00D);
        wait_rsp(n);
        chk("lit_after_flush_rdata", rsp_rdata, 32'hCAFEF00D);
        finish_rsp(1);
        send(0, 32'h0003_0000, '0, TO, 32'h0BADC0DE);
        wait_rsp(n);
        chk("lit_edge_latency", n, TO + 1);
        chk("lit_edge_err", rsp_err, 0);
        chk("lit_edge_rdata", rsp_rdata, 32'h0BADC0DE);
        finish_rsp(0);
        send(1, 32'h0000_0100, 32'h1111, 0, '0);
        req_valid = 1; req_write = 1; req_addr = 32'h0000_0200; req_wdata = 32'h2222;
        wait_rsp(n);
        repeat (10) begin
            chk("lit_hold_req_ready", req_ready, 0);
            chk("lit_hold_rsp_valid", rsp_valid, 1);
            step();
        end
        rsp_ready = 1;
        step();
        rsp_ready = 0;
        chk("lit_post_hs_ready", req_ready, 1);
        step();
        req_valid = 0;
        chk("lit_b2b_pulse", cfg_wr_en, 1);
        chk("lit_b2b_addr", cfg_wr_addr, 32'h0000_0200);
        wait_rsp(n);
        finish_rsp(0);
        send(0, 32'h0000_0300, '0, 0, '0);
        repeat (5) step();
        reset = 1;
        #1;
        chk("lit_mid_rst_rsp", rsp_valid, 0);
        chk("lit_mid_rst_addr", cfg_rd_addr, 0);
        step();
        step();
        reset = 0;
        send(1, 32'h0000_0400, 32'h4444, 0, '0);
        wait_rsp(n);
        chk("lit_post_rst_latency", n, 1);
        finish_rsp(0);
        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(0, 9);
            lat = sel == 0 ? 0 : sel == 1 ? TO : sel == 2 ? TO + 1 : sel == 3 ? 70 : int'($urandom_range(1, 20));
            a = $urandom;
            send(1'($urandom), a, $urandom, lat, $urandom);
            wait_rsp(n);
            finish_rsp(int'($urandom_range(0, 3)));
            repeat ($urandom_range(0, 3)) begin
                stray = 1'($urandom);
                step();
            end
            stray = 0;
        end
        repeat (3) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
